// File: rtl/fp_cmp_pkg.sv
// Shared types and constants for the
// shared floating-point compare service.
package fp_cmp_pkg;

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_GT = 3'd4,
    CMP_GE = 3'd5
  } cmp_op_t;

  localparam logic [31:0] FP_TRUE  = 32'h1;
  localparam logic [31:0] FP_FALSE = 32'h0;

  localparam int ID_W = 3;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     result;
    logic            err;
  } cmp_rsp_t;

endpackage

// File: rtl/fp_compare_core.sv
// Pipelined IEEE-754 single-precision
// comparator with CMP_LAT stages.
module fp_compare_core
  import fp_cmp_pkg::*;
#(
  parameter int CMP_LAT = 2
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [2:0]      op_i,
  input  logic [31:0]     a_i,
  input  logic [31:0]     b_i,
  input  logic            valid_i,
  input  logic [ID_W-1:0] id_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o,
  output logic [31:0]     result_o,
  output logic            err_o
);

  logic nan, zero, eq, lt_raw, lt, gt;
  logic true_v, err_v;
  cmp_rsp_t rsp_d;

  cmp_rsp_t pipe_q [CMP_LAT];
  logic [CMP_LAT-1:0] vld_q;

  always_comb begin
    nan = (&a_i[30:23] && |a_i[22:0]) ||
          (&b_i[30:23] && |b_i[22:0]);
    zero = ~|a_i[30:0] && ~|b_i[30:0];
    eq = !nan && ((a_i == b_i) || zero);
    // sign-magnitude ordering, reversed
    // when both operands are negative
    if (a_i[31] != b_i[31])
      lt_raw = a_i[31] && !zero;
    else if (!a_i[31])
      lt_raw = a_i[30:0] < b_i[30:0];
    else
      lt_raw = a_i[30:0] > b_i[30:0];
    lt = !nan && lt_raw;
    gt = !nan && !eq && !lt;
    true_v = 1'b0;
    err_v  = 1'b0;
    case (op_i)
      CMP_EQ:  true_v = eq;
      CMP_NE:  true_v = !eq;
      CMP_LT:  true_v = lt;
      CMP_LE:  true_v = lt || eq;
      CMP_GT:  true_v = gt;
      CMP_GE:  true_v = gt || eq;
      default: err_v  = 1'b1;
    endcase
    rsp_d.id     = id_i;
    rsp_d.result = true_v ? FP_TRUE : FP_FALSE;
    rsp_d.err    = err_v;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      vld_q <= '0;
      for (int i = 0; i < CMP_LAT; i++)
        pipe_q[i] <= '0;
    end else begin
      vld_q[0]  <= valid_i;
      pipe_q[0] <= rsp_d;
      for (int i = 1; i < CMP_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o  = vld_q[CMP_LAT-1];
  assign id_o     = pipe_q[CMP_LAT-1].id;
  assign result_o = pipe_q[CMP_LAT-1].result;
  assign err_o    = pipe_q[CMP_LAT-1].err;

endmodule

// File: rtl/fp_compare_arbiter.sv
// Round-robin front end sharing one comparator;
// credits guarantee a slot in the response FIFO.
module fp_compare_arbiter
  import fp_cmp_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int CMP_LAT    = 2,
  parameter int FIFO_DEPTH = CMP_LAT + 2
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*3-1:0]       req_op,
  input  logic [NUM_REQ*32-1:0]      req_a,
  input  logic [NUM_REQ*32-1:0]      req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_result,
  output logic                       rsp_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [IDW-1:0] last_q, gnt_id;
  logic           found, en_q;
  logic           issue, push, pop;
  logic [CW-1:0]  credit_q, count_q;
  logic [PW-1:0]  wr_q, rd_q;
  cmp_rsp_t       mem_q [FIFO_DEPTH];
  cmp_rsp_t       core_rsp, head;

  always_comb begin
    found  = 1'b0;
    gnt_id = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found &&
          req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        found  = 1'b1;
        gnt_id = IDW'((int'(last_q) + k) % NUM_REQ);
      end
    end
    req_ready = '0;
    if (found && en_q && credit_q != '0)
      req_ready[gnt_id] = 1'b1;
  end

  assign issue = |req_ready;

  fp_compare_core #(
    .CMP_LAT (CMP_LAT)
  ) u_core (
    .aclk     (aclk),
    .areset   (areset),
    .op_i     (req_op[int'(gnt_id)*3 +: 3]),
    .a_i      (req_a[int'(gnt_id)*32 +: 32]),
    .b_i      (req_b[int'(gnt_id)*32 +: 32]),
    .valid_i  (issue),
    .id_i     (ID_W'(gnt_id)),
    .valid_o  (push),
    .id_o     (core_rsp.id),
    .result_o (core_rsp.result),
    .err_o    (core_rsp.err)
  );

  assign rsp_valid = count_q != '0;
  assign pop       = rsp_valid && rsp_ready;
  assign head      = mem_q[rd_q];

  assign rsp_id     = rsp_valid ? head.id[IDW-1:0] : '0;
  assign rsp_result = rsp_valid ? head.result : FP_FALSE;
  assign rsp_err    = rsp_valid && head.err;

  always_ff @(posedge aclk) begin
    if (push)
      mem_q[wr_q] <= core_rsp;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      en_q     <= 1'b0;
      last_q   <= IDW'(NUM_REQ - 1);
      credit_q <= CW'(FIFO_DEPTH);
      count_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      en_q <= 1'b1;
      if (issue)
        last_q <= gnt_id;
      unique case ({issue, pop})
        2'b10:   credit_q <= credit_q - CW'(1);
        2'b01:   credit_q <= credit_q + CW'(1);
        default: credit_q <= credit_q;
      endcase
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push)
        wr_q <= (wr_q == PW'(FIFO_DEPTH - 1)) ?
                '0 : wr_q + PW'(1);
      if (pop)
        rd_q <= (rd_q == PW'(FIFO_DEPTH - 1)) ?
                '0 : rd_q + PW'(1);
    end
  end

endmodule

// File: tb/tb_fp_compare_arbiter.sv
// Directed bench for fp_compare_arbiter
// with hand-computed expectations.
module tb_fp_compare_arbiter;

  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   req_valid, req_ready;
  logic [11:0]  req_op;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic         rsp_err;

  int checks = 0;
  int failures = 0;

  fp_compare_arbiter #(
    .NUM_REQ    (4),
    .CMP_LAT    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx,
                         input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
    req_op[idx*3 +: 3]  = op;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
  endtask

  task automatic issue_one(input int idx,
                           input logic [2:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b);
    bit ok;
    ok = 0;
    set_req(idx, op, a, b);
    req_valid[idx] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (req_ready[idx]) begin
        ok = 1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    req_valid[idx] = 1'b0;
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  task automatic run_op(input string tag,
                        input int idx,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] er,
                        input logic ee);
    issue_one(idx, op, a, b);
    wait_rsp();
    chk({tag, "_id"}, 32'(rsp_id), idx);
    chk({tag, "_res"}, rsp_result, er);
    chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
    @(posedge aclk);
    #1;
  endtask

  int g [5];
  int rid [5];
  logic [31:0] rres [5];
  int ngnt, nrsp, n;
  bit multi, stale;

  initial begin
    areset    = 1'b1;
    req_valid = 4'hF;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_res", rsp_result, 0);
    chk("rst_err", 32'(rsp_err), 0);
    req_valid = '0;
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // first response exactly two cycles after accept
    issue_one(0, 3'd1, 32'h3fc00000, 32'h40200000);
    @(negedge aclk);
    chk("lat0", 32'(rsp_valid), 0);
    @(negedge aclk);
    chk("lat1", 32'(rsp_valid), 0);
    @(negedge aclk);
    chk("lat2", 32'(rsp_valid), 1);
    chk("ne_id", 32'(rsp_id), 0);
    chk("ne_res", rsp_result, 1);
    @(posedge aclk);
    #1;

    run_op("nan_lt", 0, 3'd2, 32'h7fc00000,
           32'h0, 0, 0);
    run_op("nan_ne", 1, 3'd1, 32'h7fc00000,
           32'h0, 1, 0);
    run_op("zero_eq", 2, 3'd0, 32'h80000000,
           32'h0, 1, 0);
    run_op("den_lt", 1, 3'd2, 32'h00000001,
           32'h00000002, 1, 0);
    run_op("neg_gt", 2, 3'd4, 32'hbf800000,
           32'hc0000000, 1, 0);
    run_op("mix_le", 0, 3'd3, 32'hbf800000,
           32'h3f800000, 1, 0);
    run_op("nan_ge", 1, 3'd5, 32'h3f800000,
           32'h7fc00000, 0, 0);
    run_op("illegal", 3, 3'd6, 32'h3f800000,
           32'h3f800000, 0, 1);

    // last grant is now 3: round robin from 0
    for (int i = 0; i < 4; i++)
      set_req(i, 3'd0, 32'h3fc00000, 32'h3fc00000);
    req_valid = 4'hF;
    ngnt  = 0;
    nrsp  = 0;
    multi = 0;
    for (int c = 0; c < 40 && nrsp < 5; c++) begin
      @(negedge aclk);
      if ($countones(req_ready) > 1) multi = 1;
      if (req_ready != 0 && ngnt < 5) begin
        for (int k = 0; k < 4; k++)
          if (req_ready[k]) g[ngnt] = k;
        ngnt++;
      end
      if (rsp_valid) begin
        rid[nrsp]  = int'(rsp_id);
        rres[nrsp] = rsp_result;
        nrsp++;
      end
      @(posedge aclk);
      #1;
      if (ngnt == 5) req_valid = '0;
    end
    chk("rr_onehot", 32'(multi), 0);
    chk("rr_nrsp", nrsp, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_gnt%0d", i), g[i], i % 4);
      chk($sformatf("rr_id%0d", i), rid[i], i % 4);
      chk($sformatf("rr_res%0d", i), rres[i], 1);
    end

    // backpressure: credit caps grants at depth
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge aclk);
      if (req_ready != 0) n++;
      @(posedge aclk);
      #1;
    end
    chk("bp_grants", n, 4);
    @(negedge aclk);
    chk("bp_ready0", 32'(req_ready), 0);
    chk("bp_valid", 32'(rsp_valid), 1);
    chk("bp_hold_id", 32'(rsp_id), 1);
    chk("bp_hold_res", rsp_result, 1);
    @(posedge aclk);
    #1;
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1;
    rsp_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (req_ready != 0) n++;
      @(posedge aclk);
      #1;
    end
    chk("bp_one_more", n, 1);
    chk("bp_next_head", 32'(rsp_id), 2);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (12) @(posedge aclk);
    @(negedge aclk);
    chk("drain_empty", 32'(rsp_valid), 0);

    // reset with two requests in flight
    @(posedge aclk);
    #1;
    req_valid = 4'b0110;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge aclk);
      if (req_ready != 0) n++;
      @(posedge aclk);
      #1;
    end
    areset    = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("inrst_ready", 32'(req_ready), 0);
    chk("inrst_valid", 32'(rsp_valid), 0);
    repeat (2) @(posedge aclk);
    #1;
    areset    = 1'b0;
    req_valid = '0;
    stale     = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      if (rsp_valid) stale = 1;
    end
    chk("no_stale", 32'(stale), 0);
    @(posedge aclk);
    #1;
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (req_ready != 0) begin
        n = 1;
        break;
      end
    end
    chk("post_rst_gnt", 32'(req_ready), 1);
    @(posedge aclk);
    #1;
    req_valid = '0;
    wait_rsp();
    chk("post_rst_id", 32'(rsp_id), 0);
    chk("post_rst_res", rsp_result, 1);
    @(posedge aclk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_compare_arbiter.md
FP_COMPARE_ARBITER -- requirements
Module: fp_compare_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the comparator, range 2..8.
REQ-002 Parameter CMP_LAT, default 2: comparator pipeline depth in cycles, range 1..4.
REQ-003 Parameter FIFO_DEPTH, default CMP_LAT+2: response buffer entries; it SHALL be at least CMP_LAT+1.
REQ-004 Port aclk  in  1  single clock; all logic on the rising edge.
REQ-005 Port areset  in  1  asynchronous, active-high reset.
REQ-006 Port req_valid  in  NUM_REQ  per-requester request valid.
REQ-007 Port req_ready  out  NUM_REQ  per-requester grant/accept.
REQ-008 Port req_op  in  NUM_REQ x 3  opcode: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE; 6 and 7 are illegal.
REQ-009 Port req_a, req_b  in  NUM_REQ x 32  IEEE-754 single-precision operands.
REQ-010 Port rsp_valid  out  1  response valid.
REQ-011 Port rsp_ready  in  1  response accept.
REQ-012 Port rsp_id  out  clog2(NUM_REQ)  index of the originating requester.
REQ-013 Port rsp_result  out  32  32'h0000_0001 when the compare is true, else 32'h0000_0000.
REQ-014 Port rsp_err  out  1  asserted when the request carried an illegal opcode.

Function
REQ-015 A request transfers when req_valid[i] and req_ready[i] are both high; at most one req_ready bit SHALL be high per cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at last_grant+1 and wraps at NUM_REQ-1 to 0. last_grant is reset to NUM_REQ-1, so requester 0 wins first.
REQ-017 req_ready SHALL depend combinationally on req_valid, last_grant and credit only; it SHALL NOT depend on rsp_ready.
REQ-018 A credit counter (reset value FIFO_DEPTH) SHALL decrement on issue and increment on the rsp_valid && rsp_ready handshake; a simultaneous issue and pop SHALL leave it unchanged.
REQ-019 No grant SHALL be given when credit is 0, so the response FIFO never overflows.
REQ-020 An issued request SHALL reach the FIFO exactly CMP_LAT cycles after acceptance; one issue per cycle SHALL be sustained while credit is greater than 0.
REQ-021 The FIFO SHALL be first-word fall-through: if it is empty and rsp_ready is high, the response is visible CMP_LAT cycles after acceptance.
REQ-022 Responses SHALL be returned in issue order.
REQ-023 rsp_id, rsp_result and rsp_err SHALL hold stable while rsp_valid is high and rsp_ready is low.
REQ-024 Compare semantics:
- +0 equals -0.
- Any NaN operand makes EQ, LT, LE, GT and GE false and NE true.
- Denormals are compared exactly, not flushed.
REQ-025 An illegal opcode SHALL consume a normal slot and return rsp_result 0 with rsp_err 1.
REQ-026 A FIFO push and pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 On areset assertion, outputs SHALL immediately go to: rsp_valid 0, req_ready all 0, rsp_id 0, rsp_result 0, rsp_err 0.
REQ-029 On areset assertion, internal state SHALL go to:
- pipeline valid bits cleared;
- FIFO emptied;
- credit set to FIFO_DEPTH;
- last_grant set to NUM_REQ-1.
REQ-030 Requests in flight when areset is asserted SHALL be discarded and produce no response.
REQ-031 The first grant SHALL occur no earlier than the first rising edge after areset deasserts.

Structure
REQ-032 Package fp_cmp_pkg SHALL hold:
- typedef enum cmp_op_t (EQ..GE);
- constant FP_TRUE = 32'h1 and FP_FALSE = 32'h0;
- the response struct {id, result, err}.
REQ-033 Sub-module fp_compare_core SHALL implement one pipelined compare:
- inputs: op, a, b, valid, id;
- latency: CMP_LAT;
- outputs: valid, id, result, err;
- reset: asynchronous on areset.
REQ-034 The arbiter, credit counter and FIFO SHALL reside in fp_compare_arbiter.

Verification
REQ-035 Test: requester 0 sends NE with a=3fc00000 (1.5), b=40200000 (2.5), rsp_ready high. Expect rsp_valid 2 cycles later with rsp_id 0 and rsp_result 1.
REQ-036 Test: all four requesters hold valid with EQ, a=b=3fc00000. Expect grants in order 0,1,2,3,0; every result 1; ids returned in grant order.
REQ-037 Test: rsp_ready held low with continuous requests. Expect exactly FIFO_DEPTH (4) grants, then req_ready 0; raise rsp_ready for one cycle and expect exactly one further grant.
REQ-038 Operand and opcode checks:
- LT with a=7fc00000 (NaN), b=0 gives result 0.
- NE with the same operands gives 1.
- EQ with a=80000000, b=00000000 gives 1.
- op=6 gives result 0 with rsp_err 1.
REQ-039 Test: assert areset while 2 requests are in flight. Expect rsp_valid 0 and no stale responses afterwards; the first grant after release goes to requester 0.
